// File: rtl/pwm_multi_ch_if.sv
// rtl/pwm_multi_ch_if.sv - duty-write handshake bundle for pwm_multi_ch
//
// Purpose: groups the duty write request/accept/error signals.
// Signals:
//   wr_valid  master->slave  write request
//   wr_chan   master->slave  target channel index
//   wr_duty   master->slave  new duty value
//   wr_ready  slave->master  write accept
//   wr_err    slave->master  sticky out-of-range channel flag
interface pwm_multi_ch_if #(
  parameter int CHAN_W = 2,
  parameter int WIDTH  = 8
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CHAN_W-1:0] wr_chan;
  logic [WIDTH-1:0]  wr_duty;
  logic              wr_err;

  modport master (
    output wr_valid, wr_chan, wr_duty,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_chan, wr_duty,
    output wr_ready, wr_err
  );
endinterface

// File: rtl/pwm_multi_ch.sv
// rtl/pwm_multi_ch.sv - parametrised multi-channel PWM generator
//
// Purpose: CHANNELS PWM outputs sharing one prescaled counter, edge- or
// center-aligned, with duty/period/mode double-buffered and committed only
// at period boundaries.
// Ports:
//   clk, resetn   clock, asynchronous active-low reset
//   enable        run control; low holds the counter idle and tracks settings
//   center_mode   0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   prescale      counter advances every prescale+1 clk
//   period        top count (taken at boundary)
//   wr            duty write handshake (slave side)
//   pwm_out       registered PWM outputs
//   period_tick   one-clk pulse after each boundary
//   count         current counter value
module pwm_multi_ch #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  center_mode,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  pwm_multi_ch_if.slave         wr,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  period_tick,
  output logic [WIDTH-1:0]      count
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PRESCALE_W-1:0] r_presc;
  logic [WIDTH-1:0]      r_count;
  dir_t                  r_dir;
  logic [WIDTH-1:0]      r_pend     [CHANNELS];
  logic [WIDTH-1:0]      r_act_duty [CHANNELS];
  logic [WIDTH-1:0]      r_act_period;
  logic                  r_act_mode;
  logic                  r_first;
  logic                  r_tick_q;
  logic                  r_err;
  logic                  r_ready;
  logic [CHANNELS-1:0]   r_pwm;

  logic [WIDTH-1:0]      w_count_next;
  dir_t                  w_dir_next;
  logic                  w_tick;
  logic                  w_bound;
  logic                  w_wr_fire;
  logic                  w_chan_ok;

  assign w_tick    = enable && (r_presc == prescale);
  assign w_wr_fire = wr.wr_valid && r_ready;
  assign w_chan_ok = {1'b0, wr.wr_chan} < (CHAN_W+1)'(CHANNELS);

  // Counter/direction successor for the next tick.
  always_comb begin
    w_count_next = r_count;
    w_dir_next   = r_dir;
    if (r_act_period == '0) begin
      w_count_next = '0;
    end else if (!r_act_mode) begin
      w_count_next = (r_count >= r_act_period) ? '0 : r_count + WIDTH'(1);
    end else if (r_dir == DIR_UP) begin
      if (r_count >= r_act_period) begin
        w_count_next = r_count - WIDTH'(1);
        w_dir_next   = DIR_DOWN;
      end else begin
        w_count_next = r_count + WIDTH'(1);
      end
    end else begin
      w_count_next = r_count - WIDTH'(1);
    end
  end

  // r_first makes the first tick after enable (or reset) a boundary.
  assign w_bound = w_tick && ((w_count_next == '0) || r_first);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc      <= '0;
      r_count      <= '0;
      r_dir        <= DIR_UP;
      r_act_period <= '0;
      r_act_mode   <= 1'b0;
      r_first      <= 1'b1;
      r_tick_q     <= 1'b0;
      r_err        <= 1'b0;
      r_ready      <= 1'b0;
      r_pwm        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_pend[i]     <= '0;
        r_act_duty[i] <= '0;
      end
    end else begin
      r_ready  <= 1'b1;
      r_tick_q <= w_bound;

      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= enable && (r_count < r_act_duty[i]);
      end

      if (w_wr_fire && !w_chan_ok) begin
        r_err <= 1'b1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_wr_fire && w_chan_ok && (wr.wr_chan == CHAN_W'(i))) begin
          r_pend[i] <= wr.wr_duty;
        end
      end

      if (!enable) begin
        // Idle: keep the active set tracking the inputs so re-enable starts fresh.
        r_presc      <= '0;
        r_count      <= '0;
        r_dir        <= DIR_UP;
        r_first      <= 1'b1;
        r_act_period <= period;
        r_act_mode   <= center_mode;
        for (int i = 0; i < CHANNELS; i++) begin
          r_act_duty[i] <= r_pend[i];
        end
      end else if (w_tick) begin
        r_presc <= '0;
        r_first <= 1'b0;
        r_count <= w_count_next;
        if (w_bound) begin
          // Active set loads the pre-edge pending values; same-edge writes wait.
          r_dir        <= DIR_UP;
          r_act_period <= period;
          r_act_mode   <= center_mode;
          for (int i = 0; i < CHANNELS; i++) begin
            r_act_duty[i] <= r_pend[i];
          end
        end else begin
          r_dir <= w_dir_next;
        end
      end else begin
        r_presc <= r_presc + PRESCALE_W'(1);
      end
    end
  end

  assign wr.wr_ready = r_ready;
  assign wr.wr_err   = r_err;
  assign pwm_out     = r_pwm;
  assign period_tick = r_tick_q;
  assign count       = r_count;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb/tb_pwm_multi_ch.sv - directed self-checking bench for pwm_multi_ch
module tb_pwm_multi_ch;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic       center_mode;
  logic [7:0] prescale;
  logic [7:0] period;

  logic [3:0] pwm4;
  logic       tick4;
  logic [7:0] count4;
  logic [2:0] pwm3;
  logic       tick3;
  logic [7:0] count3;

  int n_checks;
  int n_errors;

  logic [7:0] ctr_seq [8];

  pwm_multi_ch_if #(.CHAN_W(2), .WIDTH(8)) wr4 ();
  pwm_multi_ch_if #(.CHAN_W(2), .WIDTH(8)) wr3 ();

  pwm_multi_ch #(.CHANNELS(4), .WIDTH(8), .PRESCALE_W(8)) u_dut4 (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale    (prescale),
    .period      (period),
    .wr          (wr4),
    .pwm_out     (pwm4),
    .period_tick (tick4),
    .count       (count4)
  );

  pwm_multi_ch #(.CHANNELS(3), .WIDTH(8), .PRESCALE_W(8)) u_dut3 (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale    (prescale),
    .period      (period),
    .wr          (wr3),
    .pwm_out     (pwm3),
    .period_tick (tick3),
    .count       (count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4_write(input int ch, input int duty);
    wr4.wr_valid = 1'b1;
    wr4.wr_chan  = 2'(ch);
    wr4.wr_duty  = 8'(duty);
    step();
    wr4.wr_valid = 1'b0;
  endtask

  task automatic wr3_write(input int ch, input int duty);
    wr3.wr_valid = 1'b1;
    wr3.wr_chan  = 2'(ch);
    wr3.wr_duty  = 8'(duty);
    step();
    wr3.wr_valid = 1'b0;
  endtask

  initial begin
    int hi0;
    int k;
    n_checks     = 0;
    n_errors     = 0;
    ctr_seq      = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
    resetn       = 1'b0;
    enable       = 1'b0;
    center_mode  = 1'b0;
    prescale     = 8'd0;
    period       = 8'd9;
    wr4.wr_valid = 1'b0;
    wr4.wr_chan  = '0;
    wr4.wr_duty  = '0;
    wr3.wr_valid = 1'b0;
    wr3.wr_chan  = '0;
    wr3.wr_duty  = '0;

    // 1: reset
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t1_pwm", pwm4, 0);
      chk("t1_count", count4, 0);
      chk("t1_ready", wr4.wr_ready, 0);
      chk("t1_tick", tick4, 0);
      chk("t1_err", wr4.wr_err, 0);
    end
    resetn = 1'b1;
    chk("t1_ready_rel", wr4.wr_ready, 0);
    step();
    chk("t1_ready_up", wr4.wr_ready, 1);
    chk("t1_count_up", count4, 0);

    // 2: edge mode, period 9, ch0 duty 3
    wr4_write(0, 3);
    step();
    enable = 1'b1;
    hi0 = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("t2_count", count4, j % 10);
      if (j >= 2) chk("t2_tick", tick4, (j % 10) == 0);
      hi0 += int'(pwm4[0]);
    end
    chk("t2_hi0", hi0, 6);

    // 3: duty 0 and duty > period
    enable = 1'b0;
    step();
    wr4_write(1, 0);
    wr4_write(2, 10);
    step();
    enable = 1'b1;
    hi0 = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      chk("t3_ch21", pwm4[2:1], 2'b10);
      hi0 += int'(pwm4[0]);
    end
    chk("t3_hi0", hi0, 6);
    enable = 1'b0;
    step();
    chk("t3_off_pwm", pwm4, 0);
    chk("t3_off_count", count4, 0);

    // 4: center mode, period 4, prescale 1, ch0 duty 2
    center_mode = 1'b1;
    period      = 8'd4;
    prescale    = 8'd1;
    wr4_write(0, 2);
    step();
    enable = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      step();
      chk("t4_count", count4, ctr_seq[(j / 2) % 8]);
      chk("t4_ch0", pwm4[0], ctr_seq[((j - 1) / 2) % 8] < 8'd2);
      if (j >= 3) chk("t4_tick", tick4, (j % 16) == 0);
    end
    enable = 1'b0;
    step();

    // 5: double buffering, writes mid-period and on a boundary
    center_mode = 1'b0;
    prescale    = 8'd0;
    period      = 8'd9;
    wr4_write(1, 3);
    wr4_write(3, 0);
    step();
    enable = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      wr4.wr_valid = (j == 6) || (j == 10);
      wr4.wr_chan  = (j == 6) ? 2'd1 : 2'd3;
      wr4.wr_duty  = (j == 6) ? 8'd7 : 8'd4;
      step();
      chk("t5_count", count4, j % 10);
      chk("t5_ch1", pwm4[1], (j <= 10) ? ((j - 1) < 3) : ((j - 11) % 10 < 7));
      chk("t5_ch3", pwm4[3], (j > 20) && ((j - 21) < 4));
    end
    wr4.wr_valid = 1'b0;

    // 6: out-of-range channel, then asynchronous reset mid-period
    chk("t6_err_pre", wr3.wr_err, 0);
    wr3_write(0, 5);
    chk("t6_err_ok", wr3.wr_err, 0);
    wr3_write(3, 5);
    chk("t6_err_set", wr3.wr_err, 1);
    for (int j = 0; j < 12; j++) begin
      step();
      chk("t6_err_sticky", wr3.wr_err, 1);
      chk("t6_ch21", pwm3[2:1], 0);
    end
    k = 0;
    while (count3 != 8'd1 && k < 20) begin
      step();
      k++;
    end
    chk("t6_wait", k < 20, 1);
    chk("t6_ch0_hi", pwm3[0], 1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_pwm3", pwm3, 0);
    chk("t6_rst_err", wr3.wr_err, 0);
    chk("t6_rst_ready", wr3.wr_ready, 0);
    chk("t6_rst_count", count3, 0);
    chk("t6_rst_pwm4", pwm4, 0);
    step();
    resetn = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      chk("t6_pend_clr", pwm3, 0);
    end
    chk("t6_ready_back", wr3.wr_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
